// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter bit          FORWARD = 1'b1,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_rs_used,
  input  logic        ID_rt_used,
  input  logic        ID_is_muldiv,
  input  logic        ID_is_div,
  input  logic        ID_uses_hilo,
  input  logic        EX_RF_W_ena,
  input  logic [4:0]  EX_RF_waddr,
  input  logic        EX_is_load,
  input  logic        MEM_RF_W_ena,
  input  logic [4:0]  MEM_RF_waddr,
  input  logic        EX_branch_taken,
  input  logic        MEM_dmem_wait,
  output logic        PC_ena,
  output logic        IF_ID_ena,
  output logic        ID_EX_ena,
  output logic        EX_MEM_ena,
  output logic        MEM_WB_ena,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  // Counter reload is latency-1 so BUSY lasts exactly LAT cycles.
  localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

  md_state_t  state, state_nxt;
  logic [7:0] md_cnt, md_cnt_nxt;
  logic       hit_ex, hit_mem, raw, md_haz, stall, stall_sel;

  assign md_busy = (state == BUSY);

  // Register-file dependency checks against the EX and MEM destinations; $0 never hazards.
  always_comb begin
    hit_ex  = EX_RF_W_ena && (EX_RF_waddr != 5'd0) &&
              ((ID_rs_used && (ID_rs == EX_RF_waddr)) ||
               (ID_rt_used && (ID_rt == EX_RF_waddr)));
    hit_mem = MEM_RF_W_ena && (MEM_RF_waddr != 5'd0) &&
              ((ID_rs_used && (ID_rs == MEM_RF_waddr)) ||
               (ID_rt_used && (ID_rt == MEM_RF_waddr)));
    raw     = FORWARD ? (hit_ex && EX_is_load) : (hit_ex || hit_mem);
    md_haz  = md_busy && (ID_is_muldiv || ID_uses_hilo);
    stall   = raw || md_haz;
  end

  // Pipe-register control: memory wait freezes everything, a taken branch beats a stall.
  always_comb begin
    PC_ena      = 1'b0;
    IF_ID_ena   = 1'b0;
    ID_EX_ena   = 1'b0;
    EX_MEM_ena  = 1'b0;
    MEM_WB_ena  = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    md_start    = 1'b0;
    stall_sel   = 1'b0;
    if (!rst && !MEM_dmem_wait) begin
      ID_EX_ena  = 1'b1;
      EX_MEM_ena = 1'b1;
      MEM_WB_ena = 1'b1;
      if (EX_branch_taken) begin
        PC_ena      = 1'b1;
        IF_ID_ena   = 1'b1;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (stall) begin
        ID_EX_flush = 1'b1;
        stall_sel   = 1'b1;
      end else begin
        PC_ena    = 1'b1;
        IF_ID_ena = 1'b1;
        md_start  = ID_is_muldiv;
      end
    end
  end

  // Saturating count of cycles the front end was held by a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (stall_sel && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // MULT/DIV occupancy state and countdown register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      md_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // MULT/DIV next state; keeps counting through memory waits.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_nxt  = BUSY;
          md_cnt_nxt = ID_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (md_cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          md_cnt_nxt = md_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_is_muldiv;
    logic       id_is_div;
    logic       id_uses_hilo;
    logic       ex_w;
    logic [4:0] ex_waddr;
    logic       ex_load;
    logic       mem_w;
    logic [4:0] mem_waddr;
    logic       br;
    logic       wait_m;
  } in_t;

  typedef struct {
    string       name;
    logic [8:0]  o;
    logic [31:0] sc;
    bit          chk0;
    logic [8:0]  o0;
  } exp_t;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB, IF_ID_flush, ID_EX_flush, md_start, md_busy}
  localparam logic [8:0] O_ZERO  = 9'b00000_00_0_0;
  localparam logic [8:0] O_RUN   = 9'b11111_00_0_0;
  localparam logic [8:0] O_STALL = 9'b00111_01_0_0;
  localparam logic [8:0] O_BR    = 9'b11111_11_0_0;
  localparam logic [8:0] O_MDS   = 9'b00000_00_1_0;
  localparam logic [8:0] O_MDB   = 9'b00000_00_0_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t v, cur;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic pc1, ifid1, idex1, exmem1, memwb1, iff1, idf1, mds1, mdb1;
  logic pc0, ifid0, idex0, exmem0, memwb0, iff0, idf0, mds0, mdb0;
  logic [31:0] sc1, sc0;

  pipe_hazard_ctrl #(.FORWARD(1'b1), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst(cur.rst),
    .ID_rs(cur.id_rs), .ID_rt(cur.id_rt),
    .ID_rs_used(cur.id_rs_used), .ID_rt_used(cur.id_rt_used),
    .ID_is_muldiv(cur.id_is_muldiv), .ID_is_div(cur.id_is_div),
    .ID_uses_hilo(cur.id_uses_hilo),
    .EX_RF_W_ena(cur.ex_w), .EX_RF_waddr(cur.ex_waddr), .EX_is_load(cur.ex_load),
    .MEM_RF_W_ena(cur.mem_w), .MEM_RF_waddr(cur.mem_waddr),
    .EX_branch_taken(cur.br), .MEM_dmem_wait(cur.wait_m),
    .PC_ena(pc1), .IF_ID_ena(ifid1), .ID_EX_ena(idex1), .EX_MEM_ena(exmem1),
    .MEM_WB_ena(memwb1), .IF_ID_flush(iff1), .ID_EX_flush(idf1),
    .md_start(mds1), .md_busy(mdb1), .stall_cycles(sc1)
  );

  pipe_hazard_ctrl #(.FORWARD(1'b0), .MUL_LAT(4), .DIV_LAT(32)) dut0 (
    .clk(clk), .rst(cur.rst),
    .ID_rs(cur.id_rs), .ID_rt(cur.id_rt),
    .ID_rs_used(cur.id_rs_used), .ID_rt_used(cur.id_rt_used),
    .ID_is_muldiv(cur.id_is_muldiv), .ID_is_div(cur.id_is_div),
    .ID_uses_hilo(cur.id_uses_hilo),
    .EX_RF_W_ena(cur.ex_w), .EX_RF_waddr(cur.ex_waddr), .EX_is_load(cur.ex_load),
    .MEM_RF_W_ena(cur.mem_w), .MEM_RF_waddr(cur.mem_waddr),
    .EX_branch_taken(cur.br), .MEM_dmem_wait(cur.wait_m),
    .PC_ena(pc0), .IF_ID_ena(ifid0), .ID_EX_ena(idex0), .EX_MEM_ena(exmem0),
    .MEM_WB_ena(memwb0), .IF_ID_flush(iff0), .ID_EX_flush(idf0),
    .md_start(mds0), .md_busy(mdb0), .stall_cycles(sc0)
  );

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] g1, g0;
      e  = q.pop_front();
      g1 = {pc1, ifid1, idex1, exmem1, memwb1, iff1, idf1, mds1, mdb1};
      g0 = {pc0, ifid0, idex0, exmem0, memwb0, iff0, idf0, mds0, mdb0};
      checks++;
      if (g1 !== e.o || sc1 !== e.sc) begin
        errors++;
        $display("FAIL %s: got ctl=%b sc=%0d, want ctl=%b sc=%0d", e.name, g1, sc1, e.o, e.sc);
      end
      if (e.chk0) begin
        checks++;
        if (g0 !== e.o0) begin
          errors++;
          $display("FAIL %s/nofwd: got ctl=%b, want ctl=%b", e.name, g0, e.o0);
        end
      end
    end
  end

  task automatic step(input string name, input logic [8:0] o, input logic [31:0] sc,
                      input bit chk0 = 1'b0, input logic [8:0] o0 = 9'b0);
    exp_t e;
    @(posedge clk);
    #1;
    cur = v;
    e.name = name; e.o = o; e.sc = sc; e.chk0 = chk0; e.o0 = o0;
    q.push_back(e);
  endtask

  initial begin
    cur = '0;
    cur.rst = 1'b1;
    v = '0;

    v.rst = 1'b1;
    step("reset", O_ZERO, 0, 1, O_ZERO);
    v.id_is_muldiv = 1'b1;
    step("reset_muldiv", O_ZERO, 0, 1, O_ZERO);

    v = '0;
    step("idle", O_RUN, 0, 1, O_RUN);

    v.ex_w = 1; v.ex_waddr = 5; v.ex_load = 1; v.id_rs = 5; v.id_rs_used = 1;
    step("load_use", O_STALL, 0, 1, O_STALL);
    v.ex_w = 0; v.ex_load = 0; v.mem_w = 1; v.mem_waddr = 5;
    step("load_moved", O_RUN, 1, 1, O_STALL);

    v = '0; v.mem_w = 1; v.mem_waddr = 7; v.id_rt = 7; v.id_rt_used = 1;
    step("mem_rt7", O_RUN, 1, 1, O_STALL);
    v.mem_waddr = 0; v.id_rt = 0;
    step("mem_r0", O_RUN, 1, 1, O_RUN);

    v = '0; v.ex_w = 1; v.ex_waddr = 3; v.id_rs = 3; v.id_rs_used = 1;
    step("ex_alu_rs3", O_RUN, 1, 1, O_STALL);
    v.id_rs_used = 0;
    step("ex_rs_unused", O_RUN, 1, 1, O_RUN);

    v = '0; v.ex_w = 1; v.ex_waddr = 5; v.ex_load = 1; v.id_rs = 5; v.id_rs_used = 1; v.br = 1;
    step("branch_over_stall", O_BR, 1, 1, O_BR);
    v = '0; v.br = 1; v.id_is_muldiv = 1;
    step("branch_kills_md", O_BR, 1);
    v = '0;
    step("no_busy_after_br", O_RUN, 1);
    v.br = 1; v.wait_m = 1;
    step("wait_over_branch", O_ZERO, 1, 1, O_ZERO);

    v = '0; v.rst = 1;
    step("reset2", O_ZERO, 0);
    v = '0; v.id_is_muldiv = 1; v.id_is_div = 1;
    step("div_start", O_RUN | O_MDS, 0);
    v = '0; v.id_uses_hilo = 1;
    for (int k = 0; k < 32; k++) step("mflo_stall", O_STALL | O_MDB, 32'(k));
    step("mflo_issue", O_RUN, 32);

    v = '0; v.id_is_muldiv = 1; v.id_is_div = 1;
    step("div2_start", O_RUN | O_MDS, 32);
    v = '0; v.id_uses_hilo = 1; v.wait_m = 1;
    for (int k = 0; k < 3; k++) step("dmem_wait", O_MDB, 32);
    v.wait_m = 0;
    for (int k = 0; k < 29; k++) step("mflo_stall2", O_STALL | O_MDB, 32'(32 + k));
    step("mflo_issue2", O_RUN, 61);

    v = '0; v.id_is_muldiv = 1;
    step("mul_start", O_RUN | O_MDS, 61);
    v = '0; v.id_uses_hilo = 1;
    for (int k = 0; k < 4; k++) step("mfhi_stall", O_STALL | O_MDB, 32'(61 + k));
    step("mfhi_issue", O_RUN, 65);

    v = '0; v.id_is_muldiv = 1; v.id_is_div = 1;
    step("div3_start", O_RUN | O_MDS, 65);
    v = '0;
    for (int k = 0; k < 21; k++) step("div3_busy", O_RUN | O_MDB, 65);
    v.rst = 1; v.id_uses_hilo = 1;
    step("rst_mid_busy", O_ZERO, 0);
    v.rst = 0;
    step("mfhi_after_rst", O_RUN, 0);

    begin
      int n = 0;
      while (q.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain: got %0d pending, want 0", q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage static pipeline.
- Drives the write enables and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
- Detects RAW and load-use hazards, tracks the multi-cycle MULT/DIV unit, squashes wrong-path instructions on taken branches, and freezes the whole pipe on data-memory wait.
- Keeps a saturating stall-cycle counter for debug.

Parameters:
- FORWARD, 1, 1 = EX/MEM forwarding present (only load-use stalls); 0 = no forwarding (stall on any EX or MEM destination match).
- MUL_LAT, 4, cycles the MULT unit is busy after start (1..255).
- DIV_LAT, 32, cycles the DIV unit is busy after start (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- ID_rs_used  in  1  ID instruction reads rs.
- ID_rt_used  in  1  ID instruction reads rt.
- ID_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- ID_is_div  in  1  qualifies ID_is_muldiv: 1 = divide.
- ID_uses_hilo  in  1  ID instruction reads HI/LO (MFHI/MFLO).
- EX_RF_W_ena  in  1  EX instruction writes RF.
- EX_RF_waddr  in  5  EX destination register.
- EX_is_load  in  1  EX instruction is a load.
- MEM_RF_W_ena  in  1  MEM instruction writes RF.
- MEM_RF_waddr  in  5  MEM destination register.
- EX_branch_taken  in  1  branch/jump resolved taken in EX.
- MEM_dmem_wait  in  1  data memory not ready this cycle.
- PC_ena  out  1  PC write enable.
- IF_ID_ena  out  1  IF/ID register write enable.
- ID_EX_ena  out  1  ID/EX register write enable.
- EX_MEM_ena  out  1  EX/MEM register write enable.
- MEM_WB_ena  out  1  MEM/WB register write enable.
- IF_ID_flush  out  1  load NOP into IF/ID.
- ID_EX_flush  out  1  load bubble into ID/EX.
- md_start  out  1  start pulse to the MULT/DIV unit.
- md_busy  out  1  MULT/DIV unit occupied.
- stall_cycles  out  32  saturating count of front-end stall cycles.

Behaviour:
- Reset: rst is async, active-high. While rst=1, every output is 0: enables 0, flushes 0, md_start 0, md_busy 0, stall_cycles 0. The FSM goes to IDLE and md_cnt=0.
- Hazard terms (combinational, all with rd != 0):
  - hit_ex = EX_RF_W_ena & rd=EX_RF_waddr & (rs or rt used and equal).
  - hit_mem is the same test using the MEM_* signals.
  - raw = FORWARD ? (hit_ex & EX_is_load) : (hit_ex | hit_mem).
  - md_haz = md_busy & (ID_is_muldiv | ID_uses_hilo).
  - stall = raw | md_haz.
- Priority, highest first:
  1. MEM_dmem_wait: all five enables 0, flushes 0, md_start 0, stall_cycles unchanged. The MULT/DIV FSM still advances.
  2. EX_branch_taken: PC_ena=1, IF_ID_ena=1, IF_ID_flush=1, ID_EX_ena=1, ID_EX_flush=1, EX_MEM_ena=1, MEM_WB_ena=1, md_start=0. Branch beats stall; the ID instruction is wrong-path and is killed.
  3. stall: PC_ena=0, IF_ID_ena=0, ID_EX_ena=1, ID_EX_flush=1 (bubble), EX_MEM_ena=1, MEM_WB_ena=1, md_start=0. stall_cycles += 1, saturating at 0xFFFFFFFF.
  4. Otherwise: all enables 1, flushes 0. md_start = ID_is_muldiv.
- MULT/DIV FSM (registered):
  - IDLE: on md_start, go to BUSY and load md_cnt = (ID_is_div ? DIV_LAT : MUL_LAT) - 1.
  - BUSY: md_cnt decrements each cycle. When md_cnt=0, go to IDLE on the next edge.
  - md_busy = (state==BUSY). It is registered, so it asserts the cycle after md_start.
  - MFHI/MFLO issues in the first cycle md_busy=0.
  - md_start cannot fire while BUSY, because md_haz stalls it.
- All outputs other than md_busy and stall_cycles are combinational from inputs and state. There is no extra latency.
- rst mid-operation: BUSY aborts to IDLE immediately; the counter clears.

Test Plan:
- FORWARD=1; EX: lw $5 (EX_is_load=1, EX_RF_waddr=5); ID: add reads rs=5 → one cycle with PC_ena=0, IF_ID_ena=0, ID_EX_flush=1, stall_cycles 0→1. Next cycle (load moved on) all enables 1.
- FORWARD=0; MEM_RF_waddr=7, MEM_RF_W_ena=1; ID reads rt=7 → stall asserted. Repeat with waddr=0 → no stall.
- ID DIV with MUL_LAT=4, DIV_LAT=32 → md_start for 1 cycle, md_busy=1 for exactly 32 cycles. An MFLO held in ID stalls for those 32 cycles, then issues; stall_cycles=32.
- Load-use stall and EX_branch_taken in the same cycle → PC_ena=1, IF_ID_flush=1, ID_EX_flush=1, stall_cycles unchanged.
- MEM_dmem_wait=1 for 3 cycles during a DIV → all enables 0 for 3 cycles; md_busy still drops after 32 total cycles.
- rst pulsed mid-BUSY (md_cnt=10) → md_busy=0 and stall_cycles=0 asynchronously; an MFHI in ID issues immediately after release.
